window_gen: RTL and testbench

WINDOW_GEN -- requirements
Module: window_gen

---
 rtl/filter_pkg.sv | 24 ++
 rtl/window_gen_if.sv | 39 +++
 rtl/window_gen_line_buf.sv | 26 ++
 rtl/window_gen.sv | 175 +++++++++++++++++
 tb/tb_window_gen.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/filter_pkg.sv
// Shared constants for the 3x3 window generator: pixel width, FSM encodings
// and row-major window slot indices (1 = top-left, 9 = bottom-right).
package filter_pkg;

    localparam int PIX_W = 8;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_PRIME  = 2'd1;
    localparam state_t ST_STREAM = 2'd2;
    localparam state_t ST_DONE   = 2'd3;

    localparam int WIN_TL = 1;
    localparam int WIN_TC = 2;
    localparam int WIN_TR = 3;
    localparam int WIN_ML = 4;
    localparam int WIN_C  = 5;
    localparam int WIN_MR = 6;
    localparam int WIN_BL = 7;
    localparam int WIN_BC = 8;
    localparam int WIN_BR = 9;

endpackage

// File: rtl/window_gen_if.sv
// Pixel input stream and window output bundle of window_gen.
// slave = the window generator, master = the pixel source / window consumer.
interface window_gen_if;
    import filter_pkg::*;

    logic             pix_valid;
    logic             pix_ready;
    logic [PIX_W-1:0] pix_data;
    logic             pix_sof;
    logic [PIX_W-1:0] sw_pixels1;
    logic [PIX_W-1:0] sw_pixels2;
    logic [PIX_W-1:0] sw_pixels3;
    logic [PIX_W-1:0] sw_pixels4;
    logic [PIX_W-1:0] sw_pixels5;
    logic [PIX_W-1:0] sw_pixels6;
    logic [PIX_W-1:0] sw_pixels7;
    logic [PIX_W-1:0] sw_pixels8;
    logic [PIX_W-1:0] sw_pixels9;
    logic             en;
    logic             act;
    logic             frame_done;

    modport master (
        output pix_valid, pix_data, pix_sof,
        input  pix_ready,
        input  sw_pixels1, sw_pixels2, sw_pixels3, sw_pixels4, sw_pixels5,
        input  sw_pixels6, sw_pixels7, sw_pixels8, sw_pixels9,
        input  en, act, frame_done
    );

    modport slave (
        input  pix_valid, pix_data, pix_sof,
        output pix_ready,
        output sw_pixels1, sw_pixels2, sw_pixels3, sw_pixels4, sw_pixels5,
        output sw_pixels6, sw_pixels7, sw_pixels8, sw_pixels9,
        output en, act, frame_done
    );

endinterface

// File: rtl/window_gen_line_buf.sv
// line_buf: one image row of delay; read-before-write at the current column,
// so o_rdata is the pixel written at the same column one row earlier.
module line_buf
    import filter_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_addr,
    input  logic [PIX_W-1:0] i_wdata,
    output logic [PIX_W-1:0] o_rdata
);

    logic [PIX_W-1:0] r_mem [DEPTH];

    assign o_rdata = r_mem[i_addr];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

endmodule

// File: rtl/window_gen.sv
// window_gen: 3x3 sliding-window generator over a raster-order pixel stream.
// Defining WINDOW_GEN_STATS_EN adds a 16-bit completed-frame counter output.
//   state  | meaning
//   IDLE   | waiting for a start-of-frame pixel, others dropped
//   PRIME  | rows 0..1 filling the line buffers
//   STREAM | rows 2..IMG_H-1, windows emitted
//   DONE   | one-cycle end-of-frame pulse, input stalled
module window_gen
    import filter_pkg::*;
#(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    window_gen_if.slave s_if
`ifdef WINDOW_GEN_STATS_EN
    ,
    output logic [15:0] frame_cnt
`endif
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    state_t           r_state;
    logic [CW-1:0]    r_col;
    logic [RW-1:0]    r_row;
    logic             r_en;
    logic [PIX_W-1:0] r_top [2];
    logic [PIX_W-1:0] r_mid [2];
    logic [PIX_W-1:0] r_bot [2];
    logic [PIX_W-1:0] r_win [1:9];

    logic             w_xfer;
    logic             w_sof;
    logic             w_accept;
    logic             w_col_last;
    logic             w_row_last;
    logic             w_win_ld;
    logic [CW-1:0]    w_addr;
    logic [PIX_W-1:0] w_lb1_q;
    logic [PIX_W-1:0] w_lb2_q;

    assign w_xfer     = s_if.pix_valid && s_if.pix_ready;
    assign w_sof      = w_xfer && s_if.pix_sof;
    assign w_accept   = w_xfer && ((r_state != ST_IDLE) || s_if.pix_sof);
    assign w_col_last = (r_col == CW'(IMG_W - 1));
    assign w_row_last = (r_row == RW'(IMG_H - 1));
    // A start-of-frame pixel is always column 0, whatever the counters say.
    assign w_addr     = w_sof ? '0 : r_col;
    assign w_win_ld   = w_accept && !s_if.pix_sof && (r_state == ST_STREAM)
                        && (r_col >= CW'(2));

    line_buf #(.DEPTH(IMG_W)) u_lb1 (
        .clk     (clk),
        .i_we    (w_accept),
        .i_addr  (w_addr),
        .i_wdata (s_if.pix_data),
        .o_rdata (w_lb1_q)
    );

    line_buf #(.DEPTH(IMG_W)) u_lb2 (
        .clk     (clk),
        .i_we    (w_accept),
        .i_addr  (w_addr),
        .i_wdata (w_lb1_q),
        .o_rdata (w_lb2_q)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_col   <= '0;
            r_row   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_sof) begin
                        r_state <= ST_PRIME;
                        r_col   <= CW'(1);
                        r_row   <= '0;
                    end
                end
                ST_PRIME, ST_STREAM: begin
                    if (w_sof) begin
                        r_state <= ST_PRIME;
                        r_col   <= CW'(1);
                        r_row   <= '0;
                    end else if (w_xfer) begin
                        if (w_col_last) begin
                            r_col <= '0;
                            r_row <= r_row + RW'(1);
                        end else begin
                            r_col <= r_col + CW'(1);
                        end
                        if ((r_state == ST_PRIME) && w_col_last && (r_row == RW'(1))) begin
                            r_state <= ST_STREAM;
                        end
                        if ((r_state == ST_STREAM) && w_col_last && w_row_last) begin
                            r_state <= ST_DONE;
                            r_col   <= '0;
                            r_row   <= '0;
                        end
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Two-deep column history per window row; the third column comes live.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_top[0] <= r_top[1];
            r_top[1] <= w_lb2_q;
            r_mid[0] <= r_mid[1];
            r_mid[1] <= w_lb1_q;
            r_bot[0] <= r_bot[1];
            r_bot[1] <= s_if.pix_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_en <= 1'b0;
            for (int i = 1; i <= 9; i++) begin
                r_win[i] <= '0;
            end
        end else begin
            r_en <= w_win_ld;
            if (w_win_ld) begin
                r_win[WIN_TL] <= r_top[0];
                r_win[WIN_TC] <= r_top[1];
                r_win[WIN_TR] <= w_lb2_q;
                r_win[WIN_ML] <= r_mid[0];
                r_win[WIN_C]  <= r_mid[1];
                r_win[WIN_MR] <= w_lb1_q;
                r_win[WIN_BL] <= r_bot[0];
                r_win[WIN_BC] <= r_bot[1];
                r_win[WIN_BR] <= s_if.pix_data;
            end
        end
    end

    assign s_if.pix_ready  = (r_state != ST_DONE);
    assign s_if.act        = (r_state == ST_PRIME) || (r_state == ST_STREAM);
    assign s_if.frame_done = (r_state == ST_DONE);
    assign s_if.en         = r_en;
    assign s_if.sw_pixels1 = r_win[WIN_TL];
    assign s_if.sw_pixels2 = r_win[WIN_TC];
    assign s_if.sw_pixels3 = r_win[WIN_TR];
    assign s_if.sw_pixels4 = r_win[WIN_ML];
    assign s_if.sw_pixels5 = r_win[WIN_C];
    assign s_if.sw_pixels6 = r_win[WIN_MR];
    assign s_if.sw_pixels7 = r_win[WIN_BL];
    assign s_if.sw_pixels8 = r_win[WIN_BC];
    assign s_if.sw_pixels9 = r_win[WIN_BR];

`ifdef WINDOW_GEN_STATS_EN
    logic [15:0] r_frame_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_frame_cnt <= '0;
        end else if (r_state == ST_DONE) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    assign frame_cnt = r_frame_cnt;
`endif

endmodule

// File: tb/tb_window_gen.sv
// Directed bench for window_gen on a 5x5 ramp image (pixel = 5*row + col + offset).
module tb_window_gen;
    import filter_pkg::*;

    localparam int W = 5;
    localparam int H = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int n_assert = 0;
    int n_fail   = 0;

    logic [71:0] cap_q[$];
    int          fd_cnt     = 0;
    int          fd_at_en   = -1;
    logic        fd_with_en = 1'b0;
    int          gap_en     = 0;
    logic        prev_xfer  = 1'b0;

    window_gen_if u_if ();

`ifdef WINDOW_GEN_STATS_EN
    logic [15:0] frame_cnt;
`endif

    window_gen #(.IMG_W(W), .IMG_H(H)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .s_if  (u_if)
`ifdef WINDOW_GEN_STATS_EN
        ,
        .frame_cnt (frame_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [71:0] win_now();
        return {u_if.sw_pixels1, u_if.sw_pixels2, u_if.sw_pixels3,
                u_if.sw_pixels4, u_if.sw_pixels5, u_if.sw_pixels6,
                u_if.sw_pixels7, u_if.sw_pixels8, u_if.sw_pixels9};
    endfunction

    // Window k (0..8) of a frame, centred on row 1+k/3, column 1+k%3.
    function automatic logic [71:0] exp_win(input int k, input int off);
        int          rr;
        int          cc;
        logic [71:0] w;
        rr = 2 + k / 3;
        cc = 2 + k % 3;
        w  = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                w = {w[63:0], 8'(5 * (rr - 2 + i) + (cc - 2 + j) + off)};
            end
        end
        return w;
    endfunction

    always @(negedge clk) begin
        if (u_if.en) begin
            cap_q.push_back(win_now());
            if (!prev_xfer) gap_en++;
        end
        if (u_if.frame_done) begin
            fd_cnt++;
            fd_at_en   = cap_q.size();
            fd_with_en = u_if.en;
        end
        prev_xfer = u_if.pix_valid && u_if.pix_ready;
    end

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_mon();
        cap_q.delete();
        fd_cnt     = 0;
        fd_at_en   = -1;
        fd_with_en = 1'b0;
        gap_en     = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_px(input logic [7:0] d, input logic sof);
        int n;
        n = 0;
        u_if.pix_valid = 1'b1;
        u_if.pix_data  = d;
        u_if.pix_sof   = sof;
        while (!u_if.pix_ready && n < 8) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 8) chk("ready_timeout", {71'd0, u_if.pix_ready}, 72'd1);
        @(posedge clk);
        #1;
        u_if.pix_valid = 1'b0;
        u_if.pix_sof   = 1'b0;
    endtask

    task automatic send_range(input int off, input int p0, input int p1, input int gap);
        for (int p = p0; p <= p1; p++) begin
            drive_px(8'(p + off), (p == 0));
            idle(gap);
        end
    endtask

    task automatic chk_frame(input string tag, input int base, input int off);
        for (int k = 0; k < 9; k++) begin
            chk(tag, cap_q[base + k], exp_win(k, off));
        end
    endtask

    initial begin
        u_if.pix_valid = 1'b0;
        u_if.pix_data  = '0;
        u_if.pix_sof   = 1'b0;

        // Reset state
        rst_n = 1'b0;
        idle(2);
        chk("rst_en", {71'd0, u_if.en}, 72'd0);
        chk("rst_act", {71'd0, u_if.act}, 72'd0);
        chk("rst_fd", {71'd0, u_if.frame_done}, 72'd0);
        chk("rst_sw", win_now(), 72'd0);
        rst_n = 1'b1;
        idle(1);
        chk("rst_ready", {71'd0, u_if.pix_ready}, 72'd1);

        // Continuous frame
        clr_mon();
        send_range(0, 0, 24, 0);
        chk("cont_done_en", {71'd0, u_if.en}, 72'd1);
        chk("cont_done_fd", {71'd0, u_if.frame_done}, 72'd1);
        idle(3);
        chk("cont_count", 72'(cap_q.size()), 72'd9);
        chk_frame("cont_win", 0, 0);
        chk("cont_fd_cnt", 72'(fd_cnt), 72'd1);
        chk("cont_fd_at", 72'(fd_at_en), 72'd9);
        chk("cont_fd_with_en", {71'd0, fd_with_en}, 72'd1);
        chk("cont_hold", win_now(), exp_win(8, 0));
        chk("cont_centre", 72'(u_if.sw_pixels5), 72'd18);
        chk("cont_act_after", {71'd0, u_if.act}, 72'd0);

        // Valid pattern 1,0,0,1
        clr_mon();
        send_range(0, 0, 24, 2);
        idle(3);
        chk("gap_count", 72'(cap_q.size()), 72'd9);
        chk_frame("gap_win", 0, 0);
        chk("gap_en_in_gap", 72'(gap_en), 72'd0);
        chk("gap_fd_cnt", 72'(fd_cnt), 72'd1);

        // Valid held through DONE into the next sof frame
        clr_mon();
        send_range(0, 0, 24, 0);
        chk("done_ready", {71'd0, u_if.pix_ready}, 72'd0);
        chk("done_fd", {71'd0, u_if.frame_done}, 72'd1);
        send_range(100, 0, 24, 0);
        idle(3);
        chk("b2b_count", 72'(cap_q.size()), 72'd18);
        chk_frame("b2b_win1", 0, 0);
        chk_frame("b2b_win2", 9, 100);
        chk("b2b_fd_cnt", 72'(fd_cnt), 72'd2);

        // Abort by sof at pixel (3,2)
        clr_mon();
        send_range(0, 0, 16, 0);
        chk("abort_act", {71'd0, u_if.act}, 72'd1);
        send_range(50, 0, 0, 0);
        idle(2);
        chk("abort_no_fd", 72'(fd_cnt), 72'd0);
        chk("abort_a_count", 72'(cap_q.size()), 72'd3);
        send_range(50, 1, 24, 0);
        idle(3);
        chk("abort_count", 72'(cap_q.size()), 72'd12);
        for (int k = 0; k < 3; k++) chk("abort_a_win", cap_q[k], exp_win(k, 0));
        chk_frame("abort_b_win", 3, 50);
        chk("abort_fd_cnt", 72'(fd_cnt), 72'd1);
        chk("abort_fd_at", 72'(fd_at_en), 72'd12);

        // Reset mid-frame at pixel (2,4)
        clr_mon();
        send_range(0, 0, 13, 0);
        rst_n          = 1'b0;
        u_if.pix_valid = 1'b1;
        u_if.pix_data  = 8'd14;
        u_if.pix_sof   = 1'b0;
        idle(1);
        chk("mrst_en", {71'd0, u_if.en}, 72'd0);
        chk("mrst_act", {71'd0, u_if.act}, 72'd0);
        chk("mrst_fd", {71'd0, u_if.frame_done}, 72'd0);
        chk("mrst_sw", win_now(), 72'd0);
        chk("mrst_ready", {71'd0, u_if.pix_ready}, 72'd1);
        rst_n          = 1'b1;
        u_if.pix_valid = 1'b0;
        drive_px(8'd77, 1'b0);
        drive_px(8'd78, 1'b0);
        drive_px(8'd79, 1'b0);
        idle(3);
        chk("mrst_drop_act", {71'd0, u_if.act}, 72'd0);
        chk("mrst_count", 72'(cap_q.size()), 72'd2);
        chk("mrst_no_fd", 72'(fd_cnt), 72'd0);
        send_range(30, 0, 24, 0);
        idle(3);
        chk("mrst_next_count", 72'(cap_q.size()), 72'd11);
        chk_frame("mrst_next_win", 2, 30);
        chk("mrst_next_fd", 72'(fd_cnt), 72'd1);

`ifdef WINDOW_GEN_STATS_EN
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        chk("stats_rst", 72'(frame_cnt), 72'd0);
        for (int f = 1; f <= 3; f++) begin
            send_range(0, 0, 24, 0);
            idle(1);
            chk("stats_cnt", 72'(frame_cnt), 72'(f));
        end
        force dut.r_frame_cnt = 16'hFFFF;
        idle(1);
        release dut.r_frame_cnt;
        chk("stats_preload", 72'(frame_cnt), 72'hFFFF);
        send_range(0, 0, 24, 0);
        idle(1);
        chk("stats_wrap", 72'(frame_cnt), 72'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
